// File: rtl/tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module     : tdc_pulse_gen
// Description: Self-test stimulus generator for the TDC. Fires start/stop
//              pulse pairs a programmed number of clk cycles apart, waits for
//              the TDC to finish, checks coarse_result against the expected
//              value, and keeps saturating pass/fail tallies.
//              Optional feature macro: SWEEP_EN (per-shot gap increment).
// Revision   : 1.0 - initial release
// ============================================================================
module tdc_pulse_gen #(
    parameter int GAP_W      = 32,
    parameter int CNT_W      = 16,
    parameter int PULSE_W    = 4,
    parameter int HOLDOFF    = 8,
    parameter int TIMEOUT    = 1023,
    parameter int EXP_OFFSET = 0,
    parameter int TOL        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [GAP_W-1:0] cfg_gap_step,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic             start_signal,
    output logic             stop_signal,
    input  logic             tdc_busy,
    input  logic [GAP_W-1:0] tdc_coarse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [GAP_W-1:0] last_result,
    output logic             timeout_flag
);

    // One extra bit so gap + PULSE_W never wraps inside a shot.
    localparam int c_TICK_W = GAP_W + 1;
    localparam int c_TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [c_TICK_W-1:0] c_PULSE     = c_TICK_W'(PULSE_W);
    localparam logic [c_TICK_W-1:0] c_OFFSET    = c_TICK_W'(EXP_OFFSET);
    localparam logic [c_TICK_W-1:0] c_TOL       = c_TICK_W'(TOL);
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLDOFF - 1);
    localparam logic [GAP_W-1:0]    c_GAP_MIN   = GAP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_GAP     = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CHECK   = 3'd5,
        ST_HOLDOFF = 3'd6
    } state_t;

    state_t              r_state;
    logic [GAP_W-1:0]    r_gap;
    logic [CNT_W-1:0]    r_remaining;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_timed_out;
    logic                r_start;
    logic                r_stop;
    logic                r_busy;
    logic                r_cfg_ready;
    logic                r_done;
    logic [CNT_W-1:0]    r_pass;
    logic [CNT_W-1:0]    r_fail;
    logic [GAP_W-1:0]    r_last;
    logic                r_timeout_flag;

    logic [c_TICK_W-1:0] w_tick_next;
    logic [c_TICK_W-1:0] w_gap_ext;
    logic [c_TICK_W-1:0] w_stop_end;
    logic                w_start_next;
    logic                w_stop_next;
    logic [c_TICK_W-1:0] w_expected;
    logic [c_TICK_W-1:0] w_coarse_ext;
    logic [c_TICK_W-1:0] w_diff;
    logic                w_pass;
    logic [GAP_W-1:0]    w_gap_next;
    logic [GAP_W-1:0]    w_cfg_gap_clamped;

    // Pulse timing is derived from one shot-relative tick: tick 0 is the
    // cycle start_signal first reads high.
    assign w_tick_next  = r_tick + c_TICK_W'(1);
    assign w_gap_ext    = {1'b0, r_gap};
    assign w_stop_end   = w_gap_ext + c_PULSE;
    assign w_start_next = (w_tick_next < c_PULSE);
    assign w_stop_next  = (w_tick_next >= w_gap_ext) && (w_tick_next < w_stop_end);

    // Unsigned compare one bit wider than the gap so gap + offset cannot wrap.
    assign w_expected   = w_gap_ext + c_OFFSET;
    assign w_coarse_ext = {1'b0, tdc_coarse};
    assign w_diff       = (w_coarse_ext >= w_expected) ? (w_coarse_ext - w_expected)
                                                       : (w_expected - w_coarse_ext);
    assign w_pass       = (w_diff <= c_TOL);

    assign w_cfg_gap_clamped = (cfg_gap == '0) ? c_GAP_MIN : cfg_gap;

`ifdef SWEEP_EN
    logic [GAP_W-1:0] r_step;
    logic [GAP_W-1:0] w_gap_sum;

    assign w_gap_sum  = r_gap + r_step;
    assign w_gap_next = (w_gap_sum == '0) ? c_GAP_MIN : w_gap_sum;

    // Step is latched with the rest of the configuration on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
        end else if (r_state == ST_IDLE && cfg_valid && !abort) begin
            r_step <= cfg_gap_step;
        end
    end
`else
    // Gap stays fixed for the whole run; the step port is kept but unused.
    logic w_unused_step;
    assign w_unused_step = ^cfg_gap_step;
    assign w_gap_next    = r_gap;
`endif

    // Main sequencer: shot timing, TDC handshake, result check and tallies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_gap          <= c_GAP_MIN;
            r_remaining    <= '0;
            r_tick         <= '0;
            r_timer        <= '0;
            r_hold         <= '0;
            r_timed_out    <= 1'b0;
            r_start        <= 1'b0;
            r_stop         <= 1'b0;
            r_busy         <= 1'b0;
            r_cfg_ready    <= 1'b1;
            r_done         <= 1'b0;
            r_pass         <= '0;
            r_fail         <= '0;
            r_last         <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_start     <= 1'b0;
                r_stop      <= 1'b0;
                r_busy      <= 1'b0;
                r_cfg_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_valid) begin
                            r_gap          <= w_cfg_gap_clamped;
                            r_remaining    <= cfg_count;
                            r_pass         <= '0;
                            r_fail         <= '0;
                            r_last         <= '0;
                            r_timeout_flag <= 1'b0;
                            r_busy         <= 1'b1;
                            r_cfg_ready    <= 1'b0;
                            r_tick         <= '0;
                            r_start        <= (cfg_count != '0);
                            r_stop         <= 1'b0;
                            r_state        <= ST_START;
                        end
                    end

                    ST_START, ST_GAP, ST_STOP: begin
                        if (r_remaining == '0) begin
                            // Zero-shot run: finish without any pulses.
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end else begin
                            r_tick  <= w_tick_next;
                            r_start <= w_start_next;
                            r_stop  <= w_stop_next;
                            if (w_tick_next == w_stop_end) begin
                                r_timer <= '0;
                                r_state <= ST_WAIT;
                            end else if (w_tick_next >= w_gap_ext) begin
                                r_state <= ST_STOP;
                            end else if (w_start_next) begin
                                r_state <= ST_START;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end
                    end

                    ST_WAIT: begin
                        if (!tdc_busy) begin
                            r_timed_out <= 1'b0;
                            r_state     <= ST_CHECK;
                        end else if (r_timer == c_TMR_LAST) begin
                            r_timed_out <= 1'b1;
                            r_state     <= ST_CHECK;
                        end else begin
                            r_timer <= r_timer + c_TMR_W'(1);
                        end
                    end

                    ST_CHECK: begin
                        if (r_timed_out) begin
                            r_timeout_flag <= 1'b1;
                            if (r_fail != '1) r_fail <= r_fail + CNT_W'(1);
                        end else begin
                            r_last <= tdc_coarse;
                            if (w_pass) begin
                                if (r_pass != '1) r_pass <= r_pass + CNT_W'(1);
                            end else begin
                                if (r_fail != '1) r_fail <= r_fail + CNT_W'(1);
                            end
                        end
                        r_gap       <= w_gap_next;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end else if (HOLDOFF == 0) begin
                            r_tick  <= '0;
                            r_start <= 1'b1;
                            r_stop  <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_hold  <= '0;
                            r_state <= ST_HOLDOFF;
                        end
                    end

                    ST_HOLDOFF: begin
                        if (r_hold == c_HOLD_LAST) begin
                            r_tick  <= '0;
                            r_start <= 1'b1;
                            r_stop  <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_hold <= r_hold + c_HOLD_W'(1);
                        end
                    end

                    default: begin
                        r_state     <= ST_IDLE;
                        r_start     <= 1'b0;
                        r_stop      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign start_signal = r_start;
    assign stop_signal  = r_stop;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass_count   = r_pass;
    assign fail_count   = r_fail;
    assign last_result  = r_last;
    assign timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire
